// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern datapath: mode encoding,
// data/delta widths and the shortest legal line.
package pattern_pkg;

  localparam int DATA_W       = 12;
  localparam int DELTA_W      = 2;
  localparam int MIN_LINE_LEN = 2;

  typedef enum logic [2:0] {
    MODE_OFF       = 3'b000,
    MODE_REGULAR   = 3'b001,
    MODE_CONSTANT  = 3'b010,
    MODE_WHITE_1X1 = 3'b011,
    MODE_BLACK_1X1 = 3'b100,
    MODE_WHITE_2X2 = 3'b101,
    MODE_BLACK_2X2 = 3'b110,
    MODE_RAMP      = 3'b111
  } pattern_mode_e;

endpackage

// File: rtl/pattern_timebase.sv
// In-line cycle counter and line counter with clamped L/F latched at frame start.
// Sync, f_sync and frame_done are registered one step ahead so they line up with the counters.
module pattern_timebase
  import pattern_pkg::*;
#(
  parameter int LINE_W  = 13,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_run,
  input  logic [LINE_W-1:0]  i_line_len,
  input  logic [FRAME_W-1:0] i_lines,
  output logic               o_sync,
  output logic               o_f_sync,
  output logic               o_frame_done,
  output logic [FRAME_W-1:0] o_line_idx
);

  logic [LINE_W-1:0]  r_cnt;
  logic [LINE_W-1:0]  r_len;
  logic [FRAME_W-1:0] r_frames;
  logic [FRAME_W-1:0] r_line;
  logic               r_sync;
  logic               r_f_sync;
  logic               r_frame_done;

  logic               w_line_end;
  logic               w_frame_end;
  logic [LINE_W-1:0]  w_nxt_cnt;
  logic [FRAME_W-1:0] w_nxt_line;
  logic [LINE_W-1:0]  w_len_clamped;
  logic [FRAME_W-1:0] w_frames_clamped;

  always_comb begin
    w_line_end       = (r_cnt == r_len - LINE_W'(1));
    w_frame_end      = (r_line == r_frames - FRAME_W'(1));
    w_nxt_cnt        = r_cnt + LINE_W'(1);
    w_nxt_line       = r_line;
    w_len_clamped    = i_line_len;
    w_frames_clamped = i_lines;
    if (w_line_end) begin
      w_nxt_cnt  = '0;
      w_nxt_line = w_frame_end ? '0 : r_line + FRAME_W'(1);
    end
    if (i_line_len < LINE_W'(MIN_LINE_LEN))
      w_len_clamped = LINE_W'(MIN_LINE_LEN);
    if (i_lines == '0)
      w_frames_clamped = FRAME_W'(1);
  end

  // With L >= 2 cycle 0 can never also be the last cycle, so frame_done starts low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_len        <= LINE_W'(MIN_LINE_LEN);
      r_frames     <= FRAME_W'(1);
      r_line       <= '0;
      r_sync       <= 1'b0;
      r_f_sync     <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (i_start) begin
      r_cnt        <= '0;
      r_len        <= w_len_clamped;
      r_frames     <= w_frames_clamped;
      r_line       <= '0;
      r_sync       <= 1'b1;
      r_f_sync     <= 1'b1;
      r_frame_done <= 1'b0;
    end else if (i_run) begin
      r_cnt        <= w_nxt_cnt;
      r_line       <= w_nxt_line;
      r_sync       <= (w_nxt_cnt == '0);
      r_f_sync     <= (w_nxt_cnt == '0) && (w_nxt_line == '0);
      r_frame_done <= (w_nxt_cnt == r_len - LINE_W'(1)) &&
                      (w_nxt_line == r_frames - FRAME_W'(1));
    end else begin
      r_cnt        <= '0;
      r_line       <= '0;
      r_sync       <= 1'b0;
      r_f_sync     <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign o_sync       = r_sync;
  assign o_f_sync     = r_f_sync;
  assign o_frame_done = r_frame_done;
  assign o_line_idx   = r_line;

endmodule

// File: rtl/pattern_sync_gen.sv
// Frame/line timing master for Pattern_Generator: IDLE/RUN FSM plus frame-stable config shadows.
// Start latency one cycle from enable; frames always run to completion, back-to-back while enable holds.
module pattern_sync_gen
  import pattern_pkg::*;
#(
  parameter int LINE_W  = 13,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [LINE_W-1:0]  line_len,
  input  logic [FRAME_W-1:0] lines_per_frame,
  input  logic [2:0]         cfg_mode,
  input  logic [DATA_W-1:0]  cfg_const,
  input  logic [DELTA_W-1:0] cfg_x,
  input  logic [DELTA_W-1:0] cfg_y,
  output logic               f_sync,
  output logic               sync,
  output logic [2:0]         Mode,
  output logic [DATA_W-1:0]  constVal,
  output logic [DELTA_W-1:0] X,
  output logic [DELTA_W-1:0] Y,
  output logic [FRAME_W-1:0] line_idx,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e             r_state;
  logic               r_busy;
  pattern_mode_e      r_mode;
  logic [DATA_W-1:0]  r_const;
  logic [DELTA_W-1:0] r_x;
  logic [DELTA_W-1:0] r_y;

  logic               w_start;
  logic               w_run;
  logic               w_frame_done;

  // A new frame begins from IDLE or directly after the last cycle of the previous one.
  always_comb begin
    w_start = enable && ((r_state == ST_IDLE) || w_frame_done);
    w_run   = (r_state == ST_RUN) && !w_frame_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_mode  <= MODE_OFF;
      r_const <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_frame_done && !enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_start) begin
        r_mode  <= pattern_mode_e'(cfg_mode);
        r_const <= cfg_const;
        r_x     <= cfg_x;
        r_y     <= cfg_y;
      end
    end
  end

  pattern_timebase #(
    .LINE_W  (LINE_W),
    .FRAME_W (FRAME_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_run        (w_run),
    .i_line_len   (line_len),
    .i_lines      (lines_per_frame),
    .o_sync       (sync),
    .o_f_sync     (f_sync),
    .o_frame_done (w_frame_done),
    .o_line_idx   (line_idx)
  );

  assign frame_done = w_frame_done;
  assign busy       = r_busy;
  assign Mode       = r_mode;
  assign constVal   = r_const;
  assign X          = r_x;
  assign Y          = r_y;

endmodule

// File: tb/tb_pattern_sync_gen.sv
// Directed bench for pattern_sync_gen: basic timing, config freeze, graceful stop, clamping, mid-frame reset.
module tb_pattern_sync_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [12:0] line_len;
  logic [7:0]  lines_per_frame;
  logic [2:0]  cfg_mode;
  logic [11:0] cfg_const;
  logic [1:0]  cfg_x;
  logic [1:0]  cfg_y;
  logic        f_sync;
  logic        sync;
  logic [2:0]  Mode;
  logic [11:0] constVal;
  logic [1:0]  X;
  logic [1:0]  Y;
  logic [7:0]  line_idx;
  logic        busy;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  always #8 clk = ~clk;

  pattern_sync_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .line_len        (line_len),
    .lines_per_frame (lines_per_frame),
    .cfg_mode        (cfg_mode),
    .cfg_const       (cfg_const),
    .cfg_x           (cfg_x),
    .cfg_y           (cfg_y),
    .f_sync          (f_sync),
    .sync            (sync),
    .Mode            (Mode),
    .constVal        (constVal),
    .X               (X),
    .Y               (Y),
    .line_idx        (line_idx),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fsync"}, f_sync, 0);
    chk({tag, "_sync"}, sync, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_line"}, line_idx, 0);
    chk({tag, "_mode"}, Mode, 0);
    chk({tag, "_const"}, constVal, 0);
    chk({tag, "_x"}, X, 0);
    chk({tag, "_y"}, Y, 0);
  endtask

  localparam int L1 = 1351;
  localparam int F1 = 24;
  localparam int FRM = L1 * F1;  // 32424

  initial begin
    int nsync1 = 0, nfs1 = 0, nsync2 = 0, nfd = 0;
    int bad_pos = 0, bad_fd = 0, bad_mode = 0, late = 0;

    // Reset held with enable already high: reset must win.
    rst_n = 1'b0; enable = 1'b1;
    line_len = 13'(L1); lines_per_frame = 8'(F1);
    cfg_mode = 3'b001; cfg_const = 12'd0; cfg_x = 2'd0; cfg_y = 2'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Two back-to-back frames; config changed at line 5, enable dropped at line 10 of frame 2.
    for (int c = 0; c < 2 * FRM + 12; c++) begin
      @(negedge clk);
      if (c < FRM) begin
        if (sync) begin nsync1++; if (c % L1 != 0) bad_pos++; end
        if (f_sync) nfs1++;
        if (Mode != 3'd1 || X != 2'd0 || Y != 2'd0) bad_mode++;
      end else if (c < 2 * FRM) begin
        if (sync) nsync2++;
      end else if (sync || busy || f_sync) begin
        late++;
      end
      if (frame_done) begin
        nfd++;
        if (c != FRM - 1 && c != 2 * FRM - 1) bad_fd++;
      end
      case (c)
        0: begin
          chk("c0_fsync", f_sync, 1); chk("c0_sync", sync, 1);
          chk("c0_line", line_idx, 0); chk("c0_mode", Mode, 1); chk("c0_busy", busy, 1);
        end
        1:        chk("c1_sync", sync, 0);
        L1: begin
          chk("l1_sync", sync, 1); chk("l1_fsync", f_sync, 0); chk("l1_line", line_idx, 1);
        end
        23 * L1:  chk("l23_line", line_idx, 23);
        FRM - 2:  chk("pre_fdone", frame_done, 0);
        FRM - 1: begin
          chk("fdone1", frame_done, 1); chk("fdone1_mode", Mode, 1); chk("fdone1_x", X, 0);
        end
        FRM: begin
          chk("f2_fsync", f_sync, 1); chk("f2_line", line_idx, 0); chk("f2_mode", Mode, 7);
          chk("f2_x", X, 2); chk("f2_y", Y, 2); chk("f2_const", constVal, 12);
          chk("f2_fdone", frame_done, 0);
        end
        2 * FRM - 1: begin
          chk("fdone2", frame_done, 1); chk("fdone2_busy", busy, 1); chk("fdone2_line", line_idx, 23);
        end
        2 * FRM: begin
          chk("stop_busy", busy, 0); chk("stop_sync", sync, 0);
        end
        default: ;
      endcase
      if (c == 5 * L1) begin
        cfg_mode = 3'b111; cfg_x = 2'd2; cfg_y = 2'd2; cfg_const = 12'd12;
      end
      if (c == FRM + 10 * L1) enable = 1'b0;
    end
    chk("f1_sync_count", nsync1, 24);
    chk("f1_fsync_count", nfs1, 1);
    chk("f1_sync_pos", bad_pos, 0);
    chk("f1_shadow_stable", bad_mode, 0);
    chk("f2_sync_count", nsync2, 24);
    chk("fdone_count", nfd, 2);
    chk("fdone_pos", bad_fd, 0);
    chk("after_stop", late, 0);

    // Clamping: L=0 -> 2, F=0 -> 1.
    line_len = 13'd0; lines_per_frame = 8'd0; enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("clamp%0d_sync", c), sync, (c % 2 == 0) ? 1 : 0);
      chk($sformatf("clamp%0d_fsync", c), f_sync, (c % 2 == 0) ? 1 : 0);
      chk($sformatf("clamp%0d_fdone", c), frame_done, (c % 2 == 1) ? 1 : 0);
      chk($sformatf("clamp%0d_line", c), line_idx, 0);
      if (c == 7) enable = 1'b0;
    end
    @(negedge clk);
    chk("clamp_stop_busy", busy, 0);
    chk("clamp_stop_sync", sync, 0);

    // Reset for one cycle at line 3 of a 5x8 frame.
    line_len = 13'd5; lines_per_frame = 8'd8; enable = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 15) begin
        chk("rst_pre_line", line_idx, 3); chk("rst_pre_sync", sync, 1); chk("rst_pre_mode", Mode, 7);
      end
      if (c == 17) rst_n = 1'b0;
    end
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_fsync", f_sync, 1);
    chk("restart_sync", sync, 1);
    chk("restart_line", line_idx, 0);
    chk("restart_busy", busy, 1);
    chk("restart_mode", Mode, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_sync_gen.md
# pattern_sync_gen

Frame/line timing master that drives the sync side of `Pattern_Generator`. It produces the `f_sync` and `sync` pulses and presents `Mode`, `constVal`, `X` and `Y`. These configuration outputs are taken from shadow registers and stay frozen for a whole frame. Software-facing configuration inputs may change at any time; they reach the generator only at the next frame start. The block replaces the hand-driven stimulus used in bring-up and sits directly upstream of the generator in the pattern datapath.

## Interface
Parameters:
- `LINE_W`, 13, width of the line-length field and the in-line cycle counter (must hold 4500).
- `FRAME_W`, 8, width of the lines-per-frame field and the line index.

Ports:
- `clk`  in  1  master clock (16 ns).
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  level; run frames while high.
- `line_len`  in  LINE_W  cycles per line (sync period).
- `lines_per_frame`  in  FRAME_W  sync pulses per frame.
- `cfg_mode`  in  3  requested pattern mode.
- `cfg_const`  in  12  requested constant value.
- `cfg_x`  in  2  requested ramp deltaX.
- `cfg_y`  in  2  requested ramp deltaY.
- `f_sync`  out  1  first-line sync pulse.
- `sync`  out  1  line sync pulse.
- `Mode`  out  3  frame-stable mode to the generator.
- `constVal`  out  12  frame-stable constant.
- `X`  out  2  frame-stable deltaX.
- `Y`  out  2  frame-stable deltaY.
- `line_idx`  out  FRAME_W  current line number within the frame.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse on the last cycle of a frame.

## Operation
- Two states: IDLE and RUN.
- **IDLE → RUN:** `enable` is sampled 1 at a rising edge. That same edge starts frame cycle 0.
- **Frame start (cycle 0):**
  - latch `L` = max(`line_len`, 2) and `F` = max(`lines_per_frame`, 1);
  - load the shadows `Mode`, `constVal`, `X`, `Y` from the `cfg_*` inputs;
  - `line_idx` = 0.
- **Within RUN:**
  - the in-line counter counts 0..L-1;
  - `sync` = 1 when the counter is 0;
  - `f_sync` = 1 only when the counter is 0 and `line_idx` = 0;
  - `line_idx` increments with each `sync` after the first and wraps to 0 after F-1.
- **Last cycle of frame** (`line_idx` = F-1, counter = L-1):
  - `frame_done` = 1;
  - if `enable` = 1, the next cycle is cycle 0 of a new frame (no gap; config and L/F re-sampled);
  - otherwise go to IDLE.
- **`enable` dropped mid-frame:** the current frame completes; the block never truncates a frame.
- `cfg_*`, `line_len` and `lines_per_frame` changes mid-frame have no effect until the next frame start.
- `busy` = 1 exactly while in RUN.
- **Mode encoding:**
  - 000 off
  - 001 regular
  - 010 constant
  - 011 white 1x1
  - 100 black 1x1
  - 101 white 2x2
  - 110 black 2x2
  - 111 ramp
- `Mode` = 000 is passed through unchanged; no values are checked.

## Timing
- All outputs are registered.
- **Reset:** during and after any cycle with `rst_n` = 0:
  - state = IDLE;
  - `f_sync`, `sync`, `frame_done`, `busy` = 0;
  - `line_idx` = 0;
  - `Mode`, `constVal`, `X`, `Y` = 0.
- Reset mid-frame aborts the frame immediately; no `frame_done` is issued.
- **Latency:** `enable` sampled 1 in IDLE at edge e, so `f_sync` = `sync` = 1 in the cycle after edge e.
- **Cycle numbering** (cycle 0 = first `f_sync` cycle):
  - line n `sync` is at cycle n·L;
  - `frame_done` is at cycle F·L-1;
  - the next `f_sync` is at cycle F·L.
- **Shadow timing:** shadow outputs change only in the same cycle `f_sync` rises. They are valid and stable from that cycle through `frame_done`.
- **F = 1:** every `sync` is also an `f_sync`, and `frame_done` is on the cycle before each sync.
- **Simultaneous `rst_n` = 0 and `enable` = 1:** reset wins.

## Structure
- Shared package `pattern_pkg`:
  - mode enum `pattern_mode_e` with the encoding above;
  - constants for data width (12), delta width (2) and the minimum line length (2).
- One sub-module is natural: `pattern_timebase`.
  - It holds the in-line counter and line counter, with the load of L/F, the terminal-count flags and `line_idx`.
  - The top level holds the FSM and the shadow registers.

## Test plan
- **Basic timing:** reset, then `enable` = 1 with `line_len` = 1351, `lines_per_frame` = 24, `cfg_mode` = 001.
  - `f_sync` + `sync` appear at cycle 0 and `sync` every 1351 cycles, 24 pulses in total.
  - `frame_done` is at cycle 32423 and the next `f_sync` at 32424.
- **Config freeze:** change `cfg_mode` to 111 with `cfg_x` = `cfg_y` = 2 and `cfg_const` = 12 at line 5.
  - `Mode`/`X`/`Y` stay 001/0/0 until the next `f_sync`, then become 111/2/2 in that same cycle.
- **Graceful stop:** drop `enable` at line 10.
  - The frame finishes and `frame_done` fires once.
  - `busy` falls the next cycle and no further `sync` occurs.
- **Clamping:** `line_len` = 0 and `lines_per_frame` = 0.
  - `sync` comes every 2 cycles, each with `f_sync` = 1; `frame_done` fires every odd cycle; `line_idx` stays 0.
- **Reset mid-frame:** assert `rst_n` = 0 for one cycle at line 3.
  - All outputs are 0 in the following cycle.
  - After release with `enable` = 1, a fresh `f_sync` appears one cycle later with `line_idx` = 0.
